// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x5 active-low key matrix, debounces it and emits one newkey pulse per clean press
module keypad_scanner #(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] col_n,
    output logic [3:0] row_n,
    output logic       newkey,
    output logic [4:0] keycode
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int MW = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t        state, state_d;
    logic [4:0]    sync1, cs;
    logic [DW-1:0] div;
    logic [MW-1:0] match, match_d, match_inc;
    logic [1:0]    row, row_d;
    logic [4:0]    code, code_d, cap_code;
    logic [2:0]    zeros, col;
    logic          sample, one, none, hit, fire;

    assign sample    = div == DW'(SCAN_DIV - 1);
    assign one       = zeros == 3'd1;
    assign none      = zeros == 3'd0;
    assign cap_code  = 5'(row) * 5'd5 + 5'(col);
    assign match_inc = match + 1'b1;
    assign hit       = match_inc == MW'(DEBOUNCE_CNT);
    assign row_n     = ~(4'b0001 << row);

    // two-flop synchroniser for the asynchronous column inputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= '1;
            cs    <= '1;
        end else begin
            sync1 <= col_n;
            cs    <= sync1;
        end
    end

    // free-running row divider; its terminal count is the sample point
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) div <= '0;
        else        div <= sample ? '0 : div + 1'b1;
    end

    // count low columns and remember the index of the (last) low one
    always_comb begin
        zeros = '0;
        col   = '0;
        for (int i = 0; i < 5; i++) begin
            if (!cs[i]) begin
                zeros = zeros + 3'd1;
                col   = 3'(i);
            end
        end
    end

    // next-state logic: scan rows, debounce a single key, wait for clean release
    always_comb begin
        state_d = state;
        match_d = match;
        row_d   = row;
        code_d  = code;
        fire    = 1'b0;
        if (sample) begin
            case (state)
                SCAN: begin
                    if (one) begin
                        code_d = cap_code;
                        if (DEBOUNCE_CNT == 1) begin
                            fire    = 1'b1;
                            state_d = HELD;
                            match_d = '0;
                        end else begin
                            match_d = MW'(1);
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        row_d = row + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (one && cap_code == code) begin
                        fire    = hit;
                        state_d = hit ? HELD : DEBOUNCE;
                        match_d = hit ? '0 : match_inc;
                    end else begin
                        state_d = SCAN;
                        row_d   = row + 2'd1;
                        match_d = '0;
                    end
                end
                HELD: begin
                    if (none) begin
                        state_d = hit ? SCAN : HELD;
                        row_d   = hit ? row + 2'd1 : row;
                        match_d = hit ? '0 : match_inc;
                    end else begin
                        match_d = '0;
                    end
                end
                default: begin
                    state_d = SCAN;
                    match_d = '0;
                end
            endcase
        end
    end

    // state, counters and the registered key event
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= SCAN;
            match   <= '0;
            row     <= '0;
            code    <= '0;
            newkey  <= 1'b0;
            keycode <= '0;
        end else begin
            state   <= state_d;
            match   <= match_d;
            row     <= row_d;
            code    <= code_d;
            newkey  <= fire;
            keycode <= fire ? code_d : keycode;
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad model, sample-level reference model, directed tables and random presses
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DC = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [19:0] press = '0;
    logic [19:0] press2 = '0;
    logic [4:0]  col_n, col_n2, keycode, keycode2;
    logic [3:0]  row_n, row_n2;
    logic        newkey, newkey2;
    int          tests = 0;
    int          fails = 0;

    always #5 clock = ~clock;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
        .clock(clock), .reset(reset), .col_n(col_n),
        .row_n(row_n), .newkey(newkey), .keycode(keycode)
    );

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(1)) dut1 (
        .clock(clock), .reset(reset), .col_n(col_n2),
        .row_n(row_n2), .newkey(newkey2), .keycode(keycode2)
    );

    // physical matrix: a pressed key pulls its column low while its row is driven
    always_comb begin
        col_n  = 5'h1f;
        col_n2 = 5'h1f;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (!row_n[r] && press[r*5+c])   col_n[c]  = 1'b0;
                if (!row_n2[r] && press2[r*5+c]) col_n2[c] = 1'b0;
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int row_pat(int r);
        return 15 ^ (1 << r);
    endfunction

    // reference model, advanced once per sample point
    int   mrow, mphase, mcand, mstreak, mrel, mdiv, exp_nk, exp_code;
    int   cyc = 0, first_q = 0, pulses = 0, last_pulse = 0;
    logic rs;
    bit   did;
    event sampled;

    task automatic model_reset();
        mrow = 0; mphase = 0; mcand = 0; mstreak = 0; mrel = 0;
        mdiv = 0; exp_nk = 0; exp_code = 0;
    endtask

    task automatic emit();
        exp_nk   = 1;
        exp_code = mcand;
        mphase   = 2;
        mrel     = 0;
    endtask

    task automatic model_sample();
        int n = 0;
        int k = 0;
        for (int c = 0; c < 5; c++) begin
            if (press[mrow*5+c]) begin
                n++;
                k = mrow * 5 + c;
            end
        end
        if (mphase == 0) begin
            if (n == 1) begin
                mcand   = k;
                first_q = cyc - 1;
                if (DC == 1) emit();
                else begin
                    mstreak = 1;
                    mphase  = 1;
                end
            end else mrow = (mrow + 1) % 4;
        end else if (mphase == 1) begin
            if (n == 1 && k == mcand) begin
                mstreak++;
                if (mstreak == DC) emit();
            end else begin
                mphase = 0;
                mrow   = (mrow + 1) % 4;
            end
        end else begin
            if (n == 0) begin
                mrel++;
                if (mrel == DC) begin
                    mphase = 0;
                    mrow   = (mrow + 1) % 4;
                end
            end else mrel = 0;
        end
    endtask

    // per-cycle checker of the main instance against the model
    initial forever begin
        @(posedge clock);
        rs = reset;
        #1;
        did    = 0;
        exp_nk = 0;
        if (!rs) model_reset();
        else begin
            cyc++;
            if (mdiv == SD - 1) begin
                mdiv = 0;
                model_sample();
                did = 1;
            end else mdiv++;
        end
        chk("row_n", int'(row_n), row_pat(mrow));
        chk("newkey", int'(newkey), exp_nk);
        chk("keycode", int'(keycode), exp_code);
        if (newkey) begin
            pulses++;
            last_pulse = cyc;
        end
        if (did) ->sampled;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic wait_row(int r);
        for (int i = 0; i < 9; i++) begin
            @(sampled);
            if (mrow == r && mphase == 0) break;
        end
    endtask

    typedef struct {
        int key;
        int hold;
        int pulses;
        int code;
    } vec_t;

    vec_t       vecs[6];
    logic [3:0] seq[4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    int         p0, changes, got, nk;
    logic [3:0] prev;

    initial begin
        vecs[0] = '{0, 3, 1, 0};
        vecs[1] = '{4, 2, 0, 0};
        vecs[2] = '{4, 3, 1, 4};
        vecs[3] = '{19, 5, 1, 19};
        vecs[4] = '{12, 1, 0, 19};
        vecs[5] = '{12, 4, 1, 12};

        do_reset();

        for (int i = 0; i < 6; i++) begin
            wait_row(vecs[i].key / 5);
            p0 = pulses;
            press = '0;
            press[vecs[i].key] = 1'b1;
            repeat (vecs[i].hold) @(sampled);
            press = '0;
            repeat (6) @(sampled);
            chk($sformatf("vec%0d_pulses", i), pulses - p0, vecs[i].pulses);
            chk($sformatf("vec%0d_code", i), int'(keycode), vecs[i].code);
        end

        // long hold of key 13
        @(sampled);
        p0 = pulses;
        press[13] = 1'b1;
        repeat (200) @(posedge clock);
        #2;
        chk("hold_pulses", pulses - p0, 1);
        chk("hold_code", int'(keycode), 13);
        chk("hold_latency", last_pulse - first_q, 9);
        chk("hold_row", int'(row_n), 4'b1011);

        // asynchronous reset in the middle of the hold
        #1;
        reset = 1'b0;
        press = '0;
        #1;
        chk("arst_row", int'(row_n), 4'b1110);
        chk("arst_newkey", int'(newkey), 0);
        chk("arst_keycode", int'(keycode), 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(sampled);
            chk($sformatf("scan_seq%0d", i), int'(row_n), int'(seq[i]));
        end

        // single-sample bounce
        wait_row(2);
        p0 = pulses;
        press[13] = 1'b1;
        @(sampled);
        press = '0;
        @(sampled);
        chk("bounce_row", int'(row_n), 4'b0111);
        repeat (4) @(sampled);
        chk("bounce_pulses", pulses - p0, 0);

        // chord on row 2
        @(sampled);
        p0 = pulses;
        press[11] = 1'b1;
        press[13] = 1'b1;
        prev = row_n;
        changes = 0;
        repeat (100) begin
            @(posedge clock);
            #2;
            if (row_n != prev) changes++;
            prev = row_n;
        end
        press = '0;
        chk("chord_scan", changes, 25);
        chk("chord_pulses", pulses - p0, 0);

        // release bounce on key 7
        wait_row(1);
        p0 = pulses;
        press[7] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(sampled);
            if (pulses > p0) break;
        end
        chk("rel_first", pulses - p0, 1);
        chk("rel_first_code", int'(keycode), 7);
        press = '0;
        repeat (2) @(sampled);
        press[7] = 1'b1;
        repeat (6) @(sampled);
        chk("rel_bounce", pulses - p0, 1);
        press = '0;
        repeat (4) @(sampled);
        press[7] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(sampled);
            if (pulses > p0 + 1) break;
        end
        chk("rel_second", pulses - p0, 2);
        chk("rel_second_code", int'(keycode), 7);
        press = '0;
        repeat (6) @(sampled);

        // random presses, bounces and chords against the model
        @(sampled);
        for (int i = 0; i < 300; i++) begin
            press = '0;
            nk = int'($urandom_range(0, 3));
            if (nk == 3) nk = 1;
            repeat (nk) press[$urandom_range(0, 19)] = 1'b1;
            repeat ($urandom_range(1, 12)) @(sampled);
        end
        press = '0;

        // single-sample debounce instance
        @(negedge clock);
        reset = 1'b0;
        press2[0] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        got = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clock);
            #2;
            if (e == 3) chk("d1_pre", int'(newkey2), 0);
            if (e == 4) begin
                chk("d1_k0_pulse", int'(newkey2), 1);
                chk("d1_k0_code", int'(keycode2), 0);
            end
            if (e == 5) begin
                chk("d1_k0_single", int'(newkey2), 0);
                press2 = '0;
                press2[19] = 1'b1;
            end
            if (e > 5 && newkey2) begin
                got = e;
                break;
            end
        end
        chk("d1_k19_edge", got, 20);
        chk("d1_k19_code", int'(keycode2), 19);
        press2 = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
